// File: rtl/reflet_dma_pkg.sv
// Shared constants and state encoding for the reflet word-copy DMA engine.
package reflet_dma_pkg;
    localparam int WORDSIZE       = 16;
    localparam int BASE_ADDR_SIZE = 15;
    localparam logic [BASE_ADDR_SIZE-1:0] BASE_ADDR = 15'h7F40;
    localparam logic [WORDSIZE-1:0]       ADDR_STEP = 16'(WORDSIZE / 8);

    localparam logic [2:0] REG_SRC_LO = 3'd0;
    localparam logic [2:0] REG_SRC_HI = 3'd1;
    localparam logic [2:0] REG_DST_LO = 3'd2;
    localparam logic [2:0] REG_DST_HI = 3'd3;
    localparam logic [2:0] REG_LEN_LO = 3'd4;
    localparam logic [2:0] REG_LEN_HI = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam int         NUM_REGS   = 7;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RD,
        WAIT,
        WR,
        FINISH
    } state_t;
endpackage

// File: rtl/reflet_dma_if.sv
// Peripheral register window plus initiator bus signals of the DMA engine.
interface reflet_dma_if;
    import reflet_dma_pkg::*;

    logic                      enable;
    logic [BASE_ADDR_SIZE-1:0] addr;
    logic [7:0]                data_in;
    logic [7:0]                data_out;
    logic                      write_en;
    logic                      cpu_hold;
    logic                      bus_owner;
    logic [WORDSIZE-1:0]       m_addr;
    logic [WORDSIZE-1:0]       m_data_out;
    logic [WORDSIZE-1:0]       m_data_in;
    logic                      m_write_en;
    logic                      irq;

    modport slave (
        input  enable, addr, data_in, write_en, m_data_in,
        output data_out, cpu_hold, bus_owner, m_addr, m_data_out, m_write_en, irq
    );

    modport master (
        output enable, addr, data_in, write_en, m_data_in,
        input  data_out, cpu_hold, bus_owner, m_addr, m_data_out, m_write_en, irq
    );
endinterface

// File: rtl/reflet_dma_regs.sv
// Byte-wide register file of the DMA: address decode, write strobes and read mux.
module reflet_dma_regs
    import reflet_dma_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [BASE_ADDR_SIZE-1:0] addr,
    input  logic [7:0]                data_in,
    input  logic                      write_en,
    input  logic                      busy,
    input  logic                      step,
    input  logic                      set_done,
    output logic [7:0]                data_out,
    output logic [WORDSIZE-1:0]       src,
    output logic [WORDSIZE-1:0]       dst,
    output logic [WORDSIZE-1:0]       len,
    output logic                      irq_en,
    output logic                      done,
    output logic                      start
);
    logic [BASE_ADDR_SIZE-1:0] offset;
    logic                      in_range;
    logic [2:0]                sel;
    logic                      wr;
    logic                      ctrl_wr;

    // Addresses below the window wrap to large offsets and fall out of range.
    assign offset   = addr - BASE_ADDR;
    assign in_range = offset < BASE_ADDR_SIZE'(NUM_REGS);
    assign sel      = offset[2:0];
    assign wr       = enable & write_en & in_range;
    assign ctrl_wr  = wr & (sel == REG_CTRL);
    assign start    = ctrl_wr & data_in[CTRL_START] & ~busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (step) begin
                src <= src + ADDR_STEP;
                dst <= dst + ADDR_STEP;
                len <= len - 16'd1;
            end else if (wr && !busy) begin
                case (sel)
                    REG_SRC_LO: src[7:1]  <= data_in[7:1];
                    REG_SRC_HI: src[15:8] <= data_in;
                    REG_DST_LO: dst[7:1]  <= data_in[7:1];
                    REG_DST_HI: dst[15:8] <= data_in;
                    REG_LEN_LO: len[7:0]  <= data_in;
                    REG_LEN_HI: len[15:8] <= data_in;
                    default: ;
                endcase
            end
            if (ctrl_wr) irq_en <= data_in[CTRL_IRQ_EN];
            if (set_done) done <= 1'b1;
            else if (start || (ctrl_wr && data_in[CTRL_DONE])) done <= 1'b0;
        end
    end

    always_comb begin
        data_out = '0;
        if (enable && in_range) begin
            case (sel)
                REG_SRC_LO: data_out = src[7:0];
                REG_SRC_HI: data_out = src[15:8];
                REG_DST_LO: data_out = dst[7:0];
                REG_DST_HI: data_out = dst[15:8];
                REG_LEN_LO: data_out = len[7:0];
                REG_LEN_HI: data_out = len[15:8];
                REG_CTRL:   data_out = {5'b0, done, irq_en, busy};
                default:    data_out = '0;
            endcase
        end
    end
endmodule

// File: rtl/reflet_dma.sv
// Memory-to-memory word copy engine: freezes the CPU and drives the system bus per word.
// state  | meaning
// IDLE   | waiting for START
// HOLD   | CPU frozen, its in-flight access drains
// RD     | source address on bus
// WAIT   | source word arrives and is latched
// WR     | latched word written to destination, pointers advance
// FINISH | DONE set, CPU released
module reflet_dma
    import reflet_dma_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    reflet_dma_if.slave  bus
);
    state_t              state, state_next;
    logic [WORDSIZE-1:0] src, dst, len, word_q;
    logic                irq_en, done, start, busy, step, set_done;
    logic                cpu_hold_q, bus_owner, m_write_en;
    logic [WORDSIZE-1:0] m_addr, m_data_out;

    assign busy = (state != IDLE);

    reflet_dma_regs u_regs (
        .clk      (clk),
        .reset    (reset),
        .enable   (bus.enable),
        .addr     (bus.addr),
        .data_in  (bus.data_in),
        .write_en (bus.write_en),
        .busy     (busy),
        .step     (step),
        .set_done (set_done),
        .data_out (bus.data_out),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .irq_en   (irq_en),
        .done     (done),
        .start    (start)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_hold_q <= 1'b0;
            word_q     <= '0;
        end else begin
            state      <= state_next;
            cpu_hold_q <= (state_next != IDLE);
            if (state == WAIT) word_q <= bus.m_data_in;
        end
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        set_done   = 1'b0;
        bus_owner  = 1'b0;
        m_addr     = '0;
        m_data_out = '0;
        m_write_en = 1'b0;
        case (state)
            IDLE:   if (start) state_next = HOLD;
            HOLD:   state_next = (len == '0) ? FINISH : RD;
            RD: begin
                bus_owner  = 1'b1;
                m_addr     = src;
                state_next = WAIT;
            end
            WAIT: begin
                bus_owner  = 1'b1;
                m_addr     = src;
                state_next = WR;
            end
            WR: begin
                bus_owner  = 1'b1;
                m_addr     = dst;
                m_data_out = word_q;
                m_write_en = 1'b1;
                step       = 1'b1;
                state_next = (len == 16'd1) ? FINISH : RD;
            end
            FINISH: begin
                set_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.bus_owner  = bus_owner;
    assign bus.m_addr     = m_addr;
    assign bus.m_data_out = m_data_out;
    assign bus.m_write_en = m_write_en;
    assign bus.irq        = done & irq_en;
endmodule

// File: tb/tb_reflet_dma.sv
// Randomized scoreboard bench for reflet_dma against a word-array copy model.
module tb_reflet_dma;
    import reflet_dma_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reflet_dma_if dif();
    reflet_dma dut (.clk(clk), .reset(reset), .bus(dif));

    int total = 0;
    int bad = 0;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;
    wr_t exp_q[$];

    // System RAM: synchronous read, data valid the cycle after the address.
    always @(posedge clk) begin
        dif.m_data_in <= mem[dif.m_addr[15:1]];
        if (dif.bus_owner && dif.m_write_en) mem[dif.m_addr[15:1]] = dif.m_data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dif.bus_owner && dif.m_write_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         dif.m_addr, dif.m_data_out);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(dif.m_addr), 32'(e.addr));
                check("write_data", 32'(dif.m_data_out), 32'(e.data));
            end
        end
    end

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    task automatic reg_write(input logic [2:0] off, input logic [7:0] v);
        @(negedge clk);
        dif.enable   = 1'b1;
        dif.addr     = BASE_ADDR + 15'(off);
        dif.data_in  = v;
        dif.write_en = 1'b1;
        @(negedge clk);
        dif.write_en = 1'b0;
        dif.enable   = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] off, output logic [7:0] v);
        @(negedge clk);
        dif.enable = 1'b1;
        dif.addr   = BASE_ADDR + 15'(off);
        #1;
        v = dif.data_out;
        dif.enable = 1'b0;
    endtask

    task automatic check_reg16(input string name, input logic [2:0] off, input logic [15:0] exp);
        logic [7:0] lo, hi;
        reg_read(off, lo);
        reg_read(off + 3'd1, hi);
        check(name, {16'h0, hi, lo}, {16'h0, exp});
    endtask

    task automatic check_reg8(input string name, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] v;
        reg_read(off, v);
        check(name, 32'(v), 32'(exp));
    endtask

    // Model: ascending word-by-word copy over the reference memory image.
    task automatic model_copy(input logic [15:0] src, input logic [15:0] dst, input int n,
                              output logic [15:0] src_end, output logic [15:0] dst_end);
        logic [15:0] s, d, w;
        s = src;
        d = dst;
        for (int i = 0; i < n; i++) begin
            w = ref_mem[s[15:1]];
            ref_mem[d[15:1]] = w;
            exp_q.push_back({d, w});
            s = s + 16'd2;
            d = d + 16'd2;
        end
        src_end = s;
        dst_end = d;
    endtask

    task automatic load_regs(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        reg_write(REG_SRC_LO, src[7:0]);
        reg_write(REG_SRC_HI, src[15:8]);
        reg_write(REG_DST_LO, dst[7:0]);
        reg_write(REG_DST_HI, dst[15:8]);
        reg_write(REG_LEN_LO, len[7:0]);
        reg_write(REG_LEN_HI, len[15:8]);
    endtask

    task automatic run_copy(input logic [15:0] src, input logic [15:0] dst,
                            input logic [15:0] len, input bit ien);
        logic [15:0] s_end, d_end;
        int cycles = 0;
        bit irq_early = 1'b0;
        model_copy(src, dst, int'(len), s_end, d_end);
        load_regs(src, dst, len);
        reg_write(REG_CTRL, {6'b0, ien, 1'b1});
        while (dif.cpu_hold && cycles < 1000) begin
            if (dif.irq) irq_early = 1'b1;
            cycles++;
            @(negedge clk);
        end
        check("hold_cycles", 32'(cycles), 32'(2 + 3 * int'(len)));
        check("irq_before_done", 32'(irq_early), 32'd0);
        check("irq_after_done", 32'(dif.irq), 32'(ien));
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check_reg16("src_final", REG_SRC_LO, s_end);
        check_reg16("dst_final", REG_DST_LO, d_end);
        check_reg16("len_final", REG_LEN_LO, 16'h0000);
        check_reg8("ctrl_final", REG_CTRL, {5'b0, 1'b1, ien, 1'b0});
        check("mem_image_diffs", 32'(mem_diffs()), 32'd0);
    endtask

    initial begin
        logic [15:0] v16, s, d, l, s_end, d_end;
        logic [7:0] v8;
        int nwr, cyc;

        dif.enable   = 1'b0;
        dif.addr     = '0;
        dif.data_in  = '0;
        dif.write_en = 1'b0;
        for (int i = 0; i < 32768; i++) begin
            v16 = 16'($urandom);
            mem[i] = v16;
            ref_mem[i] = v16;
        end
        mem[16'h8000 >> 1] = 16'h1111; ref_mem[16'h8000 >> 1] = 16'h1111;
        mem[16'h8002 >> 1] = 16'h2222; ref_mem[16'h8002 >> 1] = 16'h2222;
        mem[16'h8004 >> 1] = 16'h3333; ref_mem[16'h8004 >> 1] = 16'h3333;

        repeat (3) @(negedge clk);
        check("rst_cpu_hold", 32'(dif.cpu_hold), 32'd0);
        check("rst_bus_owner", 32'(dif.bus_owner), 32'd0);
        check("rst_m_write_en", 32'(dif.m_write_en), 32'd0);
        check("rst_m_addr", 32'(dif.m_addr), 32'd0);
        check("rst_m_data_out", 32'(dif.m_data_out), 32'd0);
        check("rst_irq", 32'(dif.irq), 32'd0);
        reset = 1'b1;
        check_reg16("rst_src", REG_SRC_LO, 16'h0);
        check_reg16("rst_dst", REG_DST_LO, 16'h0);
        check_reg16("rst_len", REG_LEN_LO, 16'h0);
        check_reg8("rst_ctrl", REG_CTRL, 8'h00);

        // Basic copy with fixed data.
        run_copy(16'h8000, 16'h8100, 16'd3, 1'b0);
        check("basic_word0", 32'(mem[16'h8100 >> 1]), 32'h1111);
        check("basic_word1", 32'(mem[16'h8102 >> 1]), 32'h2222);
        check("basic_word2", 32'(mem[16'h8104 >> 1]), 32'h3333);

        // Interrupt, then clear DONE while keeping IRQ_EN.
        run_copy(16'h8010, 16'h8110, 16'd1, 1'b1);
        reg_write(REG_CTRL, 8'h06);
        check("irq_cleared", 32'(dif.irq), 32'd0);
        check_reg8("ctrl_irq_en_only", REG_CTRL, 8'h02);

        // Zero length.
        run_copy(16'h8020, 16'h8120, 16'd0, 1'b0);

        // Source wraps past 0xFFFE.
        run_copy(16'hFFFE, 16'h8200, 16'd2, 1'b0);
        check("wrap_word1", 32'(mem[16'h8202 >> 1]), 32'(ref_mem[0]));

        // Alignment and window decode.
        reg_write(REG_SRC_LO, 8'h35);
        check_reg8("src_lo_aligned", REG_SRC_LO, 8'h34);
        reg_write(REG_DST_LO, 8'hFF);
        check_reg8("dst_lo_aligned", REG_DST_LO, 8'hFE);
        check_reg8("out_of_range", 3'd7, 8'h00);
        @(negedge clk);
        dif.enable = 1'b0;
        dif.addr   = BASE_ADDR + 15'(REG_SRC_LO);
        #1;
        check("unselected_read", 32'(dif.data_out), 32'd0);
        dif.enable = 1'b1;
        dif.addr   = BASE_ADDR - 15'd1;
        #1;
        check("below_window_read", 32'(dif.data_out), 32'd0);
        dif.enable = 1'b0;

        // Random copies, some overlapping.
        for (int t = 0; t < 10; t++) begin
            s = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 1) == 1)
                d = s + 16'($urandom_range(0, 8) * 2) - 16'd8;
            else
                d = 16'($urandom) & 16'hFFFE;
            l = 16'($urandom_range(0, 8));
            run_copy(s, d, l, 1'($urandom_range(0, 1)));
        end

        // Reset during the fourth WR of a 10-word copy.
        model_copy(16'h9000, 16'h9100, 4, s_end, d_end);
        load_regs(16'h9000, 16'h9100, 16'd10);
        reg_write(REG_CTRL, 8'h01);
        nwr = 0;
        cyc = 0;
        while (nwr < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dif.bus_owner && dif.m_write_en) nwr++;
        end
        check("midrst_writes_seen", 32'(nwr), 32'd4);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cpu_hold", 32'(dif.cpu_hold), 32'd0);
        check("midrst_bus_owner", 32'(dif.bus_owner), 32'd0);
        check("midrst_m_write_en", 32'(dif.m_write_en), 32'd0);
        reset = 1'b1;
        check_reg16("midrst_src", REG_SRC_LO, 16'h0);
        check_reg16("midrst_dst", REG_DST_LO, 16'h0);
        check_reg16("midrst_len", REG_LEN_LO, 16'h0);
        check_reg8("midrst_ctrl", REG_CTRL, 8'h00);
        repeat (5) @(negedge clk);
        check("midrst_outstanding", 32'(exp_q.size()), 32'd0);
        check("midrst_mem_image", 32'(mem_diffs()), 32'd0);
        reg_read(REG_CTRL, v8);
        check("midrst_idle", 32'(v8[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
